bcd_stopwatch: RTL and testbench

//  MM:SS.cc stopwatch driven by the single-cycle enable pulse from the upstream tick divider
//  (one pulse per 10 ms base period).

---
 rtl/bcd_stopwatch_if.sv | 21 ++
 rtl/bcd_stopwatch.sv | 127 ++++++++++++
 tb/tb_bcd_stopwatch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_if.sv
// Control pulses into the MM:SS.cc stopwatch and the display/status signals coming out of it.
interface bcd_stopwatch_if;
   logic        tick_en;
   logic        start_stop;
   logic        clear;
   logic        lap;
   logic [23:0] disp_bcd;
   logic        running;
   logic        lap_active;
   logic        rollover;

   modport master (
      output tick_en, start_stop, clear, lap,
      input  disp_bcd, running, lap_active, rollover
   );

   modport slave (
      input  tick_en, start_stop, clear, lap,
      output disp_bcd, running, lap_active, rollover
   );
endinterface

// File: rtl/bcd_stopwatch.sv
// MM:SS.cc BCD stopwatch with start/stop/clear/lap control, counting base ticks from an
// upstream divider through an optional prescaler, with wrap or saturate at 59:59.99.
module bcd_stopwatch #(
   parameter int unsigned PRESCALE = 1,
   parameter bit          WRAP     = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   bcd_stopwatch_if.slave bus
);
   localparam int unsigned      PSC_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(PRESCALE - 1);
   localparam logic [23:0]      DIGIT_MAX = 24'h595999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [23:0]      live_q, live_d;
   logic [23:0]      snap_q, snap_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             lapActive_q, lapActive_d;
   logic             rollover_q, rollover_d;
   logic             step;

   // Each digit rolls to zero at its own maximum (taken from DIGIT_MAX) and carries upward.
   function automatic logic [23:0] bcdIncrement(input logic [23:0] v);
      logic [23:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      live_d      = live_q;
      snap_d      = snap_q;
      psc_d       = psc_q;
      lapActive_d = lapActive_q;
      rollover_d  = 1'b0;
      step        = 1'b0;

      if (bus.clear) begin
         state_d     = IDLE;
         live_d      = '0;
         psc_d       = '0;
         lapActive_d = 1'b0;
      end else begin
         // Only the registered RUN state counts, so a tick alongside start_stop in PAUSE is lost.
         if (state_q == RUN && bus.tick_en) begin
            if (psc_q == PSC_LAST) begin
               psc_d = '0;
               step  = 1'b1;
            end else begin
               psc_d = psc_q + PSC_W'(1);
            end
         end

         if (step) begin
            if (live_q == DIGIT_MAX) begin
               rollover_d = 1'b1;
               if (WRAP) begin
                  live_d = '0;
               end else begin
                  state_d = PAUSE;
               end
            end else begin
               live_d = bcdIncrement(live_q);
            end
         end

         if (bus.start_stop) begin
            case (state_q)
               IDLE:    state_d = RUN;
               RUN:     state_d = PAUSE;
               PAUSE:   state_d = RUN;
               default: state_d = IDLE;
            endcase
         end else if (bus.lap && state_q != IDLE) begin
            // The snapshot takes the pre-edge live value, never a tick counted on this edge.
            if (!lapActive_q) begin
               lapActive_d = 1'b1;
               snap_d      = live_q;
            end else begin
               lapActive_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         live_q      <= '0;
         snap_q      <= '0;
         psc_q       <= '0;
         lapActive_q <= 1'b0;
         rollover_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         live_q      <= live_d;
         snap_q      <= snap_d;
         psc_q       <= psc_d;
         lapActive_q <= lapActive_d;
         rollover_q  <= rollover_d;
      end
   end

   assign bus.disp_bcd   = lapActive_q ? snap_q : live_q;
   assign bus.running    = (state_q == RUN);
   assign bus.lap_active = lapActive_q;
   assign bus.rollover   = rollover_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: three instances (wrap, prescale-by-4, saturate) share one
// stimulus stream; a vector table covers control corner cases, hand sequences cover long counts.
module tb_bcd_stopwatch;
   logic clk = 1'b0;
   logic rst_n;
   logic tick, ss, clr, lp;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      bit          t, s, c, l;
      logic [23:0] disp;
      bit          run, lapA;
      logic [23:0] disp4;
   } vec_t;

   vec_t vecs[16];

   bcd_stopwatch_if busA ();
   bcd_stopwatch_if busB ();
   bcd_stopwatch_if busC ();

   assign busA.tick_en = tick;
   assign busA.start_stop = ss;
   assign busA.clear = clr;
   assign busA.lap = lp;
   assign busB.tick_en = tick;
   assign busB.start_stop = ss;
   assign busB.clear = clr;
   assign busB.lap = lp;
   assign busC.tick_en = tick;
   assign busC.start_stop = ss;
   assign busC.clear = clr;
   assign busC.lap = lp;

   bcd_stopwatch #(.PRESCALE(1), .WRAP(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(busA));
   bcd_stopwatch #(.PRESCALE(4), .WRAP(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(busB));
   bcd_stopwatch #(.PRESCALE(1), .WRAP(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(busC));

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive one cycle of pulses, then return just after the edge that sampled them.
   task automatic applyStimulus(input logic t, input logic s, input logic c, input logic l);
      tick = t;
      ss   = s;
      clr  = c;
      lp   = l;
      @(posedge clk);
      #1;
      tick = 1'b0;
      ss   = 1'b0;
      clr  = 1'b0;
      lp   = 1'b0;
   endtask

   task automatic runTicks(input int n);
      repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 24'h000000};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0, 24'h000000};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000002, 1'b1, 1'b0, 24'h000000};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000002, 1'b1, 1'b0, 24'h000000};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000003, 1'b0, 1'b0, 24'h000000};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000003, 1'b0, 1'b0, 24'h000000};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000003, 1'b1, 1'b0, 24'h000000};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000004, 1'b1, 1'b0, 24'h000001};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000004, 1'b1, 1'b1, 24'h000001};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000004, 1'b1, 1'b1, 24'h000001};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h000006, 1'b1, 1'b0, 24'h000001};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h000006, 1'b1, 1'b1, 24'h000001};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000007, 1'b1, 1'b0, 24'h000001};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000};

      rst_n = 1'b0;
      tick  = 1'b0;
      ss    = 1'b0;
      clr   = 1'b0;
      lp    = 1'b0;
      #23 rst_n = 1'b1;
      @(posedge clk);
      #1;

      checkOutput("rst_disp", busA.disp_bcd, 24'h000000);
      checkOutput("rst_running", busA.running, 24'h0);
      checkOutput("rst_lap", busA.lap_active, 24'h0);
      checkOutput("rst_rollover", busA.rollover, 24'h0);
      checkOutput("rst_disp4", busB.disp_bcd, 24'h000000);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].t, vecs[i].s, vecs[i].c, vecs[i].l);
         checkOutput($sformatf("v%0d_disp", i), busA.disp_bcd, vecs[i].disp);
         checkOutput($sformatf("v%0d_running", i), busA.running, 24'(vecs[i].run));
         checkOutput($sformatf("v%0d_lap", i), busA.lap_active, 24'(vecs[i].lapA));
         checkOutput($sformatf("v%0d_rollover", i), busA.rollover, 24'h0);
         checkOutput($sformatf("v%0d_disp_sat", i), busC.disp_bcd, vecs[i].disp);
         checkOutput($sformatf("v%0d_disp4", i), busB.disp_bcd, vecs[i].disp4);
      end

      // Run 1.00 s, then pause and confirm further ticks are ignored.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runTicks(100);
      checkOutput("run100_disp", busA.disp_bcd, 24'h000100);
      checkOutput("run100_disp4", busB.disp_bcd, 24'h000025);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runTicks(50);
      checkOutput("pause_disp", busA.disp_bcd, 24'h000100);
      checkOutput("pause_running", busA.running, 24'h0);
      checkOutput("pause_disp4", busB.disp_bcd, 24'h000025);

      // Carry chain up to the minutes digit, plus prescaler boundary on the /4 instance.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runTicks(5999);
      checkOutput("carry_005999", busA.disp_bcd, 24'h005999);
      runTicks(1);
      checkOutput("carry_010000", busA.disp_bcd, 24'h010000);
      checkOutput("carry_disp4", busB.disp_bcd, 24'h001500);
      runTicks(3);
      checkOutput("psc3_disp4", busB.disp_bcd, 24'h001500);
      runTicks(1);
      checkOutput("psc4_disp4", busB.disp_bcd, 24'h001501);
      runTicks(4);
      checkOutput("psc8_disp4", busB.disp_bcd, 24'h001502);
      checkOutput("psc8_disp", busA.disp_bcd, 24'h010008);

      // Lap freeze while live counting continues.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runTicks(50);
      checkOutput("lap_pre", busA.disp_bcd, 24'h000050);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lap_active_set", busA.lap_active, 24'h1);
      runTicks(30);
      checkOutput("lap_frozen", busA.disp_bcd, 24'h000050);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lap_release_disp", busA.disp_bcd, 24'h000080);
      checkOutput("lap_release_flag", busA.lap_active, 24'h0);

      // Clear beats start_stop and tick in the same cycle.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runTicks(1234);
      checkOutput("pre_clear", busA.disp_bcd, 24'h001234);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("clear_prio_disp", busA.disp_bcd, 24'h000000);
      checkOutput("clear_prio_running", busA.running, 24'h0);
      runTicks(1);
      checkOutput("idle_tick", busA.disp_bcd, 24'h000000);

      // Async reset mid-RUN takes effect without a clock edge.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runTicks(5);
      checkOutput("pre_reset", busA.disp_bcd, 24'h000005);
      rst_n = 1'b0;
      #2;
      checkOutput("async_rst_disp", busA.disp_bcd, 24'h000000);
      checkOutput("async_rst_running", busA.running, 24'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Overflow: preload 59:59.90 into the paused wrap and saturate instances.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      force dut1.live_q = 24'h595990;
      force dut0.live_q = 24'h595990;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      release dut1.live_q;
      release dut0.live_q;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("preload_wrap", busA.disp_bcd, 24'h595990);
      checkOutput("preload_sat", busC.disp_bcd, 24'h595990);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      runTicks(9);
      checkOutput("max_wrap", busA.disp_bcd, 24'h595999);
      checkOutput("max_sat", busC.disp_bcd, 24'h595999);
      checkOutput("max_rollover", busA.rollover, 24'h0);
      runTicks(1);
      checkOutput("wrap_disp", busA.disp_bcd, 24'h000000);
      checkOutput("wrap_rollover", busA.rollover, 24'h1);
      checkOutput("wrap_running", busA.running, 24'h1);
      checkOutput("sat_disp", busC.disp_bcd, 24'h595999);
      checkOutput("sat_rollover", busC.rollover, 24'h1);
      checkOutput("sat_running", busC.running, 24'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_rollover_end", busA.rollover, 24'h0);
      checkOutput("sat_rollover_end", busC.rollover, 24'h0);
      runTicks(1);
      checkOutput("wrap_continue", busA.disp_bcd, 24'h000001);
      checkOutput("sat_hold", busC.disp_bcd, 24'h595999);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("sat_rerun", busC.running, 24'h1);
      runTicks(1);
      checkOutput("sat_again_disp", busC.disp_bcd, 24'h595999);
      checkOutput("sat_again_rollover", busC.rollover, 24'h1);
      checkOutput("sat_again_running", busC.running, 24'h0);
      checkOutput("wrap_paused", busA.disp_bcd, 24'h000001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
